// File: rtl/fp16_mant_round_stage.sv
// ---------------------------------------------------------------------------
// fp16_mant_round_stage
//
// Back end of the FP16 multiplier. It takes the two partial-product addends
// left by the Dadda tree and turns them into a packed binary16 result.
// Two registered stages are connected by a valid/ready handshake:
//   stage 1 : carry-propagate add of the two addends
//   stage 2 : 1-bit normalization, round-to-nearest-even, exponent range
//             handling and packing
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready input handshake
//   in_addend0/1      22-bit tree addends
//   in_sign           product sign
//   in_exp            signed ea+eb-15, before normalization
//   in_special        forward in_special_val unchanged (NaN/Inf/zero)
//   in_special_val    binary16 value used for special beats
//   out_valid/ready   output handshake
//   out_result        {sign, exp[4:0], mant[9:0]}
//   out_ovf           result overflowed to infinity
//   out_uf            result flushed to zero
//   out_inexact       precision was lost
// ---------------------------------------------------------------------------
module fp16_mant_round_stage #(
    parameter int EXP_W    = 8,
    parameter int BIAS_MAX = 31
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [21:0]             in_addend0,
    input  logic [21:0]             in_addend1,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic                    in_special,
    input  logic [15:0]             in_special_val,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_result,
    output logic                    out_ovf,
    output logic                    out_uf,
    output logic                    out_inexact
);

    // One extra bit so that the +1 from normalization and the +1 from a
    // rounding carry can never wrap the exponent.
    localparam logic signed [EXP_W:0] BIAS_E = (EXP_W + 1)'(BIAS_MAX);
    localparam logic signed [EXP_W:0] ZERO_E = '0;

    logic                    s1_valid;
    logic [21:0]             s1_p;
    logic                    s1_sign;
    logic signed [EXP_W-1:0] s1_exp;
    logic                    s1_special;
    logic [15:0]             s1_special_val;

    logic s2_load;
    logic s1_load;

    // Each stage may load when it is empty or when its content moves on in
    // the same cycle; this gives full throughput with out_ready held high.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Stage 1: final carry-propagate add. Payload is only captured for real
    // beats so an idle input bus does not toggle the stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_p           <= '0;
            s1_sign        <= 1'b0;
            s1_exp         <= '0;
            s1_special     <= 1'b0;
            s1_special_val <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p           <= in_addend0 + in_addend1;
                s1_sign        <= in_sign;
                s1_exp         <= in_exp;
                s1_special     <= in_special;
                s1_special_val <= in_special_val;
            end
        end
    end

    logic [9:0]              norm_m;
    logic                    norm_g;
    logic                    norm_s;
    logic signed [EXP_W:0]   norm_e;
    logic                    rnd_up;
    logic [10:0]             m_sum;
    logic signed [EXP_W:0]   e_rnd;
    logic                    is_ovf;
    logic                    is_uf;
    logic [15:0]             nxt_result;
    logic                    nxt_ovf;
    logic                    nxt_uf;
    logic                    nxt_inexact;

    // Stage 2 datapath: normalize on P[21], round to nearest even, then
    // clamp the exponent to infinity or flush to zero.
    always_comb begin
        norm_m      = '0;
        norm_g      = 1'b0;
        norm_s      = 1'b0;
        norm_e      = {s1_exp[EXP_W-1], s1_exp};
        rnd_up      = 1'b0;
        m_sum       = '0;
        e_rnd       = '0;
        is_ovf      = 1'b0;
        is_uf       = 1'b0;
        nxt_result  = '0;
        nxt_ovf     = 1'b0;
        nxt_uf      = 1'b0;
        nxt_inexact = 1'b0;

        if (s1_p[21]) begin
            norm_m = s1_p[20:11];
            norm_g = s1_p[10];
            norm_s = |s1_p[9:0];
            norm_e = {s1_exp[EXP_W-1], s1_exp} + ZERO_E + (EXP_W + 1)'(1);
        end else begin
            norm_m = s1_p[19:10];
            norm_g = s1_p[9];
            norm_s = |s1_p[8:0];
        end

        rnd_up = norm_g && (norm_s || norm_m[0]);
        m_sum  = {1'b0, norm_m} + {10'b0, rnd_up};
        // A carry out of the mantissa leaves m_sum[9:0] at zero already,
        // so only the exponent needs to absorb it.
        e_rnd  = norm_e + $signed({{EXP_W{1'b0}}, m_sum[10]});

        is_ovf = (e_rnd >= BIAS_E);
        is_uf  = (e_rnd <= ZERO_E);

        if (s1_special) begin
            nxt_result = s1_special_val;
        end else if (is_ovf) begin
            nxt_result  = {s1_sign, 5'h1F, 10'h000};
            nxt_ovf     = 1'b1;
            nxt_inexact = 1'b1;
        end else if (is_uf) begin
            nxt_result  = {s1_sign, 15'h0000};
            nxt_uf      = 1'b1;
            nxt_inexact = |s1_p;
        end else begin
            nxt_result  = {s1_sign, e_rnd[4:0], m_sum[9:0]};
            nxt_inexact = norm_g | norm_s;
        end
    end

    // Stage 2 output register. A bubble clears out_valid but leaves the
    // last result in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_ovf     <= 1'b0;
            out_uf      <= 1'b0;
            out_inexact <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= nxt_result;
                out_ovf     <= nxt_ovf;
                out_uf      <= nxt_uf;
                out_inexact <= nxt_inexact;
            end
        end
    end

endmodule

// File: tb/tb_fp16_mant_round_stage.sv
// ---------------------------------------------------------------------------
// tb_fp16_mant_round_stage
//
// Self-checking bench for fp16_mant_round_stage. Expected results come from
// an integer reference model and are queued when a beat is accepted, then
// popped when the DUT hands a result downstream. Directed cases cover the
// exact, normalizing, rounding and range-limit corners; random traffic with
// and without backpressure covers the handshake.
// ---------------------------------------------------------------------------
module tb_fp16_mant_round_stage;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [21:0]       in_addend0;
    logic [21:0]       in_addend1;
    logic              in_sign;
    logic signed [7:0] in_exp;
    logic              in_special;
    logic [15:0]       in_special_val;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_result;
    logic              out_ovf;
    logic              out_uf;
    logic              out_inexact;

    int numChecks = 0;
    int numErrors = 0;
    int outBeats  = 0;
    logic [18:0] expQ[$];

    fp16_mant_round_stage #(.EXP_W(8), .BIAS_MAX(31)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addend0     (in_addend0),
        .in_addend1     (in_addend1),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_special     (in_special),
        .in_special_val (in_special_val),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_ovf        (out_ovf),
        .out_uf         (out_uf),
        .out_inexact    (out_inexact)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    // Reference model written in terms of the value of P: keep the top 11
    // significant bits, compare the discarded remainder against one half.
    // Returns {result[15:0], ovf, uf, inexact}.
    function automatic logic [18:0] model(input logic [21:0] a0, input logic [21:0] a1,
                                          input logic sg, input logic signed [7:0] ex,
                                          input logic sp, input logic [15:0] sv);
        logic [21:0] p;
        int pi, shift, keep, rem, half, frac, e;
        if (sp) return {sv, 3'b000};
        p     = a0 + a1;
        pi    = p;
        shift = p[21] ? 11 : 10;
        e     = ex;
        e     = e + (p[21] ? 1 : 0);
        keep  = pi >> shift;
        rem   = pi & ((1 << shift) - 1);
        half  = 1 << (shift - 1);
        frac  = keep & 1023;
        if (rem > half || (rem == half && (frac % 2) == 1)) frac = frac + 1;
        if (frac == 1024) begin
            frac = 0;
            e    = e + 1;
        end
        if (e >= 31) return {sg, 5'h1F, 10'h000, 3'b101};
        if (e <= 0)  return {sg, 15'h0000, 2'b01, (pi != 0)};
        return {sg, e[4:0], frac[9:0], 2'b00, (rem != 0)};
    endfunction

    // Scoreboard monitor, sampling on the falling edge: what it sees is what
    // transfers on the next rising edge.
    logic        prevStall = 1'b0;
    logic [19:0] prevSnap;
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall)
                checkOutput("stall hold", {out_valid, out_result, out_ovf, out_uf, out_inexact},
                            prevSnap);
            if (out_valid && out_ready) begin
                outBeats++;
                checkOutput("beat expected", (expQ.size() != 0), 1);
                if (expQ.size() != 0)
                    checkOutput("result", {out_result, out_ovf, out_uf, out_inexact},
                                expQ.pop_front());
            end
            if (in_valid && in_ready)
                expQ.push_back(model(in_addend0, in_addend1, in_sign, in_exp,
                                     in_special, in_special_val));
            prevStall = out_valid && !out_ready;
            prevSnap  = {out_valid, out_result, out_ovf, out_uf, out_inexact};
        end
    end

    // Offer one beat and hold it until accepted. Called and returns just
    // after a rising edge. Reports the number of cycles it took.
    task automatic applyStimulus(input logic [21:0] a0, input logic [21:0] a1,
                                 input logic sg, input logic signed [7:0] ex,
                                 input logic sp, input logic [15:0] sv,
                                 output int cycles);
        logic acc;
        in_valid       = 1'b1;
        in_addend0     = a0;
        in_addend1     = a1;
        in_sign        = sg;
        in_exp         = ex;
        in_special     = sp;
        in_special_val = sv;
        cycles         = 0;
        acc            = 1'b0;
        while (!acc && cycles < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!acc) checkOutput("accept timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Directed beat through an empty pipeline: checks the 2-cycle latency
    // and the value against a hand-derived constant.
    task automatic runDirected(input string tag, input logic [21:0] a0, input logic [21:0] a1,
                               input logic sg, input logic signed [7:0] ex,
                               input logic sp, input logic [15:0] sv,
                               input logic [18:0] want);
        int cyc;
        applyStimulus(a0, a1, sg, ex, sp, sv, cyc);
        @(negedge clk);
        checkOutput({tag, " latency1"}, out_valid, 0);
        @(negedge clk);
        checkOutput({tag, " latency2"}, out_valid, 1);
        checkOutput(tag, {out_result, out_ovf, out_uf, out_inexact}, want);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int total;
        int accepted;
        int beatsBefore;
        int seen;
        logic [21:0] bpA0[3];
        logic signed [7:0] bpEx[3];

        rst            = 1'b1;
        in_valid       = 1'b0;
        in_addend0     = '0;
        in_addend1     = '0;
        in_sign        = 1'b0;
        in_exp         = '0;
        in_special     = 1'b0;
        in_special_val = '0;
        out_ready      = 1'b0;

        #2;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out", {out_result, out_ovf, out_uf, out_inexact}, 0);
        checkOutput("reset in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post-reset in_ready", in_ready, 1);

        // Directed corners with the output always ready
        out_ready = 1'b1;
        runDirected("exact",    22'h0FFFFF, 22'h000001, 1'b0, 8'sd15,  1'b0, 16'h0,    {16'h3C00, 3'b000});
        runDirected("norm",     22'h120000, 22'h120000, 1'b0, 8'sd15,  1'b0, 16'h0,    {16'h4080, 3'b000});
        runDirected("rne tie",  22'h100000, 22'h000600, 1'b0, 8'sd15,  1'b0, 16'h0,    {16'h3C02, 3'b001});
        runDirected("rnd carry",22'h1FFE00, 22'h000000, 1'b0, 8'sd15,  1'b0, 16'h0,    {16'h4000, 3'b001});
        runDirected("ovf",      22'h200000, 22'h000000, 1'b0, 8'sd30,  1'b0, 16'h0,    {16'h7C00, 3'b101});
        runDirected("ovf wide", 22'h200000, 22'h000000, 1'b1, 8'sd127, 1'b0, 16'h0,    {16'hFC00, 3'b101});
        runDirected("uf",       22'h100000, 22'h000000, 1'b1, 8'sd0,   1'b0, 16'h0,    {16'h8000, 3'b011});
        runDirected("min norm", 22'h100000, 22'h000000, 1'b0, 8'sd1,   1'b0, 16'h0,    {16'h0400, 3'b000});
        runDirected("max exp",  22'h100000, 22'h000000, 1'b0, 8'sd30,  1'b0, 16'h0,    {16'h7800, 3'b000});
        runDirected("special",  22'h3FFFFF, 22'h3FFFFF, 1'b1, 8'sd40,  1'b1, 16'h7E00, {16'h7E00, 3'b000});

        // Back-to-back random beats: one accepted per cycle
        total = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(22'($urandom), 22'($urandom), 1'($urandom),
                          8'($urandom_range(0, 40) - 5), ($urandom_range(0, 7) == 0),
                          16'($urandom), cyc);
            total += cyc;
        end
        checkOutput("throughput cycles", total, 20);

        // Backpressure: offer 3 beats with the output stalled
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        bpA0[0] = 22'h180000; bpA0[1] = 22'h0C0400; bpA0[2] = 22'h2A0000;
        bpEx[0] = 8'sd10;     bpEx[1] = 8'sd20;     bpEx[2] = 8'sd5;
        accepted = 0;
        for (int c = 0; c < 5; c++) begin
            logic acc;
            in_valid   = (accepted < 3);
            in_addend0 = bpA0[accepted % 3];
            in_addend1 = 22'h000123;
            in_sign    = accepted[0];
            in_exp     = bpEx[accepted % 3];
            in_special = 1'b0;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) accepted++;
        end
        checkOutput("bp accepted", accepted, 2);
        checkOutput("bp in_ready", in_ready, 0);
        checkOutput("bp out_valid", out_valid, 1);
        beatsBefore = outBeats;
        out_ready   = 1'b1;
        applyStimulus(bpA0[2], 22'h000123, 1'b0, bpEx[2], 1'b0, 16'h0, cyc);
        checkOutput("bp third accept cycles", cyc, 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("bp drain beats", outBeats - beatsBefore, 3);
        @(negedge clk);
        #1;
        checkOutput("bp no duplicate", out_valid, 0);
        @(posedge clk);
        #1;

        // Random traffic with random output stalls
        begin
            logic doneSend;
            doneSend = 1'b0;
            fork
                begin
                    for (int i = 0; i < 30; i++)
                        applyStimulus(22'($urandom), 22'($urandom), 1'($urandom),
                                      8'($urandom_range(0, 40) - 5), ($urandom_range(0, 7) == 0),
                                      16'($urandom), cyc);
                    doneSend = 1'b1;
                end
                begin
                    while (!doneSend) begin
                        out_ready = 1'($urandom_range(0, 1));
                        @(posedge clk);
                        #1;
                    end
                end
            join
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain", expQ.size(), 0);

        // Reset while two beats are in flight
        applyStimulus(22'h100000, 22'h000000, 1'b0, 8'sd15, 1'b0, 16'h0, cyc);
        applyStimulus(22'h200000, 22'h000000, 1'b1, 8'sd12, 1'b0, 16'h0, cyc);
        checkOutput("inflight out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst out_valid", out_valid, 0);
        checkOutput("async rst out", {out_result, out_ovf, out_uf, out_inexact}, 0);
        checkOutput("async rst in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("post-reset idle", seen, 0);
        checkOutput("post-reset queue", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/fp16_mant_round_stage.md
Name: fp16_mant_round_stage

Overview:
- Pipelined back end of the FP16 multiplier datapath; sits directly downstream of the 11-bit Dadda reduction tree.
- Consumes the tree's two 22-bit addends together with the sign, pre-biased exponent and special-case info that travel alongside them.
- Performs the final carry-propagate add, 1-bit normalization, round-to-nearest-even and exponent overflow/underflow handling.
- Produces a packed IEEE-754 binary16 result through two registered stages with valid/ready flow control.

Parameters:
- EXP_W, 8, width of the signed input exponent (two's complement).
- BIAS_MAX, 31, all-ones biased exponent value; results at or above it become infinity.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept the beat this cycle.
- in_addend0  in  22  tree addend 0.
- in_addend1  in  22  tree addend 1.
- in_sign  in  1  product sign (sa XOR sb).
- in_exp  in  EXP_W  signed ea+eb-15, before normalization.
- in_special  in  1  bypass arithmetic; upstream detected NaN, Inf or zero.
- in_special_val  in  16  binary16 value forwarded when in_special=1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  16  {sign, exp[4:0], mant[9:0]}.
- out_ovf  out  1  overflow to infinity occurred.
- out_uf  out  1  flushed to zero.
- out_inexact  out  1  guard or sticky bit was nonzero.

Behaviour:
- Reset (async, rst=1): all valid bits clear; out_result=16'h0000; out_ovf, out_uf, out_inexact all 0. in_ready=1 during and after reset.
- A reset asserted mid-operation discards all in-flight beats with no partial outputs.
- Handshake: a beat transfers when valid&ready on that interface.
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 loads when !s1_valid || s2_load.
  - in_ready = !s1_valid || s2_load; this is combinational from out_ready.
  - Holding out_ready=1 gives full throughput of 1 beat/cycle.
  - Latency is exactly 2 cycles from accepted input to out_valid when there is no stall.
- While out_valid=1 && out_ready=0, out_* stay stable and no beat is lost or duplicated.
- Stage 1 (registered):
  - P = (in_addend0 + in_addend1) mod 2^22.
  - Register P, sign, exp, special and special_val.
- Stage 2 (registered output):
  - Normalization when P[21]=1: m=P[20:11], g=P[10], s=|P[9:0], e=exp+1.
  - Normalization when P[21]=0: m=P[19:10], g=P[9], s=|P[8:0], e=exp.
  - RNE: round up when g && (s || m[0]). Rounding carry out of m[9] sets m=0 and e=e+1.
  - Width rule: compute e at EXP_W+1 bits, signed, with no wrap.
  - If e >= BIAS_MAX: out_result={sign,5'h1F,10'h0}, out_ovf=1.
  - Else if e <= 0: out_result={sign,15'h0}, out_uf=1 (flush-to-zero, no subnormals).
  - Else: out_result={sign,e[4:0],m}.
  - out_inexact = g|s, and is also 1 for ovf and for uf with P≠0.
- Special beats: out_result=in_special_val; out_ovf, out_uf and out_inexact are all 0; P is ignored.
- A simultaneous in_valid and out_ready with the pipeline full makes input and output transfer in the same cycle.

Test Plan:
- Exact product:
  - Stimulus: addend0=22'h0FFFFF, addend1=22'h000001, sign=0, exp=15.
  - Required: out_result=16'h3C00 two cycles later; inexact=0.
- Normalization shift:
  - Stimulus: addends summing to 22'h240000 (1.5×1.5), exp=15.
  - Required: 16'h4080; ovf, uf and inexact all 0.
- Rounding:
  - P=22'h100600, exp=15 gives 16'h3C02 with inexact=1 (tie, odd LSB, rounds up).
  - P=22'h1FFE00, exp=15 gives 16'h4000 (mantissa carry bumps the exponent).
- Range limits:
  - exp=30 with P[21]=1 gives 16'h7C00 with ovf=1.
  - exp=0, sign=1, P=22'h100000 gives 16'h8000 with uf=1.
  - in_special=1, in_special_val=16'h7E00 gives 16'h7E00 with all flags 0.
- Backpressure:
  - Stimulus: out_ready=0, offer 3 beats.
  - Required: only 2 accepted and in_ready=0 afterwards; out_result holds steady.
  - Then raise out_ready: all 3 results emerge in order, none lost or duplicated, 1 per cycle.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously while 2 beats are in flight.
  - Required: out_valid drops immediately and out_result=0; no stale beat after rst deasserts.
